// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate_bist logic-gate self-test block:
// FSM state encoding, gate function codes and vector/counter sizing.
package gate_bist_pkg;

    localparam int NUM_VEC = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        GATE_AND  = 2'b00,
        GATE_OR   = 2'b01,
        GATE_XOR  = 2'b10,
        GATE_NAND = 2'b11
    } gate_t;

endpackage

// File: rtl/gate_bist_settle_cnt.sv
// Down-counter that times the settle interval between driving a vector and
// sampling the gate response.
module gate_bist_settle_cnt
    import gate_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // High during the settle cycle whose decrement takes the count to zero.
    assign zero = (cnt == CNT_W'(1));

endmodule

// File: rtl/gate_bist.sv
// Built-in self test for a two-input logic gate: applies the four input
// vectors and compares the response. Optional macro GATE_BIST_LOG_EN adds sample_log.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         gate_sel,
    output logic               dut_a,
    output logic               dut_b,
    input  logic               dut_x,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] fail_mask
`ifdef GATE_BIST_LOG_EN
    ,
    output logic [NUM_VEC-1:0] sample_log
`endif
);

    state_t             state, state_nxt;
    gate_t              sel_q;
    logic [IDX_W-1:0]   idx;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic               expect_x;
    logic               last_vec;
    logic [NUM_VEC-1:0] mask_upd;

    gate_bist_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_W'(SETTLE_CYC)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Expected response for the stimulus currently on dut_a/dut_b.
    always_comb begin
        expect_x = 1'b0;
        case (sel_q)
            GATE_AND:  expect_x = dut_a & dut_b;
            GATE_OR:   expect_x = dut_a | dut_b;
            GATE_XOR:  expect_x = dut_a ^ dut_b;
            GATE_NAND: expect_x = ~(dut_a & dut_b);
            default:   expect_x = 1'b0;
        endcase
    end

    assign last_vec = (idx == IDX_W'(NUM_VEC - 1));

    always_comb begin
        mask_upd      = fail_mask;
        mask_upd[idx] = fail_mask[idx] | (dut_x != expect_x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_DRIVE;
            ST_DRIVE: begin
                cnt_load  = 1'b1;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: state_nxt = last_vec ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= GATE_AND;
            idx       <= '0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    sel_q     <= gate_t'(gate_sel);
                    idx       <= '0;
                    busy      <= 1'b1;
                    pass      <= 1'b0;
                    fail_mask <= '0;
                end
                ST_DRIVE: begin
                    dut_a <= idx[0];
                    dut_b <= idx[1];
                end
                ST_SAMPLE: begin
                    fail_mask <= mask_upd;
                    if (last_vec) begin
                        // Stimulus returns to idle level and the verdict is
                        // visible while done is high.
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                        pass  <= (mask_upd == '0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef GATE_BIST_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_log <= '0;
        end else if (state == ST_IDLE && start) begin
            sample_log <= '0;
        end else if (state == ST_SAMPLE) begin
            sample_log[idx] <= dut_x;
        end
    end
`endif

endmodule

// File: tb/tb_gate_bist.sv
// Directed self-checking bench for gate_bist with a behavioural AND gate
// (optionally stuck at 1) as the gate under test.
module tb_gate_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] gate_sel = 2'b00;
    logic       dut_a, dut_b, dut_x;
    logic       busy, done, pass;
    logic [3:0] fail_mask;
`ifdef GATE_BIST_LOG_EN
    logic [3:0] sample_log;
`endif
    logic       stuck_hi = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int         done_cyc;
    int         n_done;
    logic [1:0] ab1, ab3;

    always #5 clk = ~clk;

    assign dut_x = stuck_hi | (dut_a & dut_b);

    gate_bist #(.SETTLE_CYC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .gate_sel  (gate_sel),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_x     (dut_x),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask)
`ifdef GATE_BIST_LOG_EN
        ,
        .sample_log(sample_log)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then watches a bounded window counting done pulses.
    // Cycle 0 is the cycle in which start is high.
    task automatic run_seq(input logic [1:0] sel, input int restart_at);
        gate_sel = sel;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        done_cyc = -1;
        n_done   = 0;
        ab1      = 2'bxx;
        ab3      = 2'bxx;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 6)  ab1 = {dut_a, dut_b};
            if (cyc == 14) ab3 = {dut_a, dut_b};
            start = (cyc == restart_at);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check("reset_ctrl", {3'b0, busy, done, pass, dut_a, dut_b}, 8'h00);
        check("reset_mask", {4'b0, fail_mask}, 8'h00);
        rst_n = 1'b1;

        // AND gate, AND expected: clean pass, done on cycle 17.
        run_seq(2'b00, 0);
        check("and_done_cyc", 8'(done_cyc), 8'd17);
        check("and_done_cnt", 8'(n_done), 8'd1);
        check("and_vec1_ab", {6'b0, ab1}, 8'b10);
        check("and_vec3_ab", {6'b0, ab3}, 8'b11);
        check("and_pass", {7'b0, pass}, 8'h01);
        check("and_mask", {4'b0, fail_mask}, 8'h00);
        check("and_idle", {5'b0, busy, dut_a, dut_b}, 8'h00);
`ifdef GATE_BIST_LOG_EN
        check("and_log", {4'b0, sample_log}, 8'b1000);
`endif

        // AND gate checked against OR, XOR, NAND.
        run_seq(2'b01, 0);
        check("or_pass", {7'b0, pass}, 8'h00);
        check("or_mask", {4'b0, fail_mask}, 8'b0110);
        repeat (3) tick();
        check("or_mask_hold", {4'b0, fail_mask}, 8'b0110);
        run_seq(2'b10, 0);
        check("xor_mask", {4'b0, fail_mask}, 8'b1110);
        run_seq(2'b11, 0);
        check("nand_mask", {4'b0, fail_mask}, 8'b1111);
        check("nand_done_cyc", 8'(done_cyc), 8'd17);

        // Stuck-at-1 output against AND.
        stuck_hi = 1'b1;
        run_seq(2'b00, 0);
        check("stuck_mask", {4'b0, fail_mask}, 8'b0111);
        check("stuck_pass", {7'b0, pass}, 8'h00);
`ifdef GATE_BIST_LOG_EN
        check("stuck_log", {4'b0, sample_log}, 8'b1111);
`endif
        stuck_hi = 1'b0;

        // Second start during a run is ignored.
        run_seq(2'b00, 5);
        check("restart_done_cyc", 8'(done_cyc), 8'd17);
        check("restart_done_cnt", 8'(n_done), 8'd1);
        check("restart_pass", {7'b0, pass}, 8'h01);

        // Reset during SETTLE of vector 2 (cycle 10) with stuck-at-1 output.
        stuck_hi = 1'b1;
        gate_sel = 2'b00;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (9) tick();
        check("pre_rst_busy", {7'b0, busy}, 8'h01);
        check("pre_rst_mask", {4'b0, fail_mask}, 8'b0011);
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", {5'b0, busy, dut_a, dut_b}, 8'h00);
        check("rst_mask", {4'b0, fail_mask}, 8'h00);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) n_done++;
            tick();
        end
        check("rst_no_done", 8'(n_done), 8'd0);
        rst_n    = 1'b1;
        stuck_hi = 1'b0;
        run_seq(2'b00, 0);
        check("post_rst_done_cyc", 8'(done_cyc), 8'd17);
        check("post_rst_pass", {7'b0, pass}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, giving the number of settle cycles between driving a vector and sampling the response (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, request to run one full test sequence.
REQ-005 The block SHALL have port gate_sel, input, 2 bits, expected gate function: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-006 The block SHALL have port dut_a, output, 1 bit, the A stimulus to the gate under test.
REQ-007 The block SHALL have port dut_b, output, 1 bit, the B stimulus to the gate under test.
REQ-008 The block SHALL have port dut_x, input, 1 bit, the response from the gate under test.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a sequence runs.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse at the end of a sequence.
REQ-011 The block SHALL have port pass, output, 1 bit, high when all four vectors matched.
REQ-012 The block SHALL have port fail_mask, output, 4 bits; bit i is set when vector i mismatched.

Function
REQ-013 Vector i (0..3) SHALL drive dut_a = i[0] and dut_b = i[1], giving the order 00, 10, 01, 11 as (A,B).
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE, start=1 SHALL latch gate_sel, clear pass, clear fail_mask, clear the vector index, assert busy and enter DRIVE.
REQ-016 DRIVE SHALL register dut_a and dut_b for the current vector, load the settle counter with SETTLE_CYC, and enter SETTLE.
REQ-017 SETTLE SHALL hold the stimulus and decrement the counter each cycle, entering SAMPLE after exactly SETTLE_CYC cycles.
REQ-018 SAMPLE SHALL compare dut_x with the latched expected function of (A,B), and set fail_mask[i] on mismatch.
REQ-019 After SAMPLE, the FSM SHALL enter DRIVE for the next vector, or enter DONE after vector 3.
REQ-020 DONE SHALL pulse done for one cycle, set pass = (fail_mask == 0), deassert busy, drive dut_a = dut_b = 0, and return to IDLE.
REQ-021 The sequence SHALL take 4*(SETTLE_CYC+2) cycles in DRIVE, SETTLE and SAMPLE; done is high in the cycle that follows.
REQ-022 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-023 pass and fail_mask SHALL hold their values until the next accepted start.
REQ-024 In IDLE, dut_a and dut_b SHALL be 0.

Reset
REQ-025 When rst_n=0, the block SHALL immediately enter IDLE and force dut_a, dut_b, busy, done, pass, fail_mask, the counter and the vector index to 0.
REQ-026 Reset asserted mid-sequence SHALL abort the run with no done pulse.
REQ-027 After rst_n rises, the block SHALL accept start on the first rising clock edge.

Configuration
REQ-028 When the macro GATE_BIST_LOG_EN is defined, the block SHALL have a 4-bit output sample_log, where bit i is the raw dut_x captured in SAMPLE for vector i.
REQ-029 sample_log SHALL be cleared on reset and on an accepted start.
REQ-030 When GATE_BIST_LOG_EN is not defined, the sample_log port and its register SHALL be absent, with no other change in behaviour.

Structure
REQ-031 The shared package gate_bist_pkg SHALL hold the FSM state encoding, the gate_sel codes, and the constant NUM_VEC=4.
REQ-032 The settle counter SHALL be the sub-module gate_bist_settle_cnt, with ports load, load value, and a zero flag.
REQ-033 The expected-value function SHALL be combinational logic inside gate_bist.

Verification
REQ-034 With an AND DUT, gate_sel=00, SETTLE_CYC=2 and a start pulse: done SHALL pulse 17 cycles after start, with pass=1 and fail_mask=0000.
REQ-035 With an AND DUT and gate_sel=01 (OR expected): the result SHALL be pass=0 and fail_mask=0110.
REQ-036 With dut_x stuck at 1 and gate_sel=00: the result SHALL be fail_mask=0111 and pass=0.
REQ-037 A second start pulse 5 cycles into a run SHALL be ignored: exactly one done pulse occurs, at the same cycle as with no second pulse.
REQ-038 rst_n low during the SETTLE of vector 2 SHALL give busy=0, fail_mask=0000 and dut_a=dut_b=0 with no done pulse; a new start then completes normally.
REQ-039 With GATE_BIST_LOG_EN defined, an AND DUT and gate_sel=00, the result SHALL be sample_log=1000.
